// File: rtl/pa_dma_pkg.sv
// DMA controller shared types: FSM states, register offsets, ctrl/status bit positions.
// Latency: none (types only). Backpressure: not applicable.
package pa_dma;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] REG_SRC_LO = 3'd0;
    localparam logic [2:0] REG_SRC_HI = 3'd1;
    localparam logic [2:0] REG_DST_LO = 3'd2;
    localparam logic [2:0] REG_DST_HI = 3'd3;
    localparam logic [2:0] REG_CNT_LO = 3'd4;
    localparam logic [2:0] REG_CNT_HI = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;

    localparam int CTRL_START  = 0;
    localparam int CTRL_DEC    = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_ABORT  = 3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

endpackage

// File: rtl/dma_controller.sv
// Bus-master DMA: copies a programmed byte block memory->memory while the CPU grants the bus.
// Latency: one byte per READ/WRITE pair (2 cycles); grant checked after each WRITE, pairs never split.
// Backpressure: dma_ack low parks the engine in REQ indefinitely; outputs decode registered state only.
module dma_controller
    import pa_dma::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [7:0]        cfg_wdata,
    output logic [7:0]        status,
    output logic              irq,
    output logic              dma_req,
    input  logic              dma_ack,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              dec_q, dec_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              abort_pend_q, abort_pend_d;

    logic busy, ctrl_wr, abort_req, start_req;

    always_comb begin
        busy      = (state_q == ST_REQ) || (state_q == ST_READ) || (state_q == ST_WRITE);
        ctrl_wr   = cfg_we && (cfg_addr == REG_CTRL);
        abort_req = ctrl_wr && cfg_wdata[CTRL_ABORT];
        start_req = ctrl_wr && cfg_wdata[CTRL_START];
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        cnt_d        = cnt_q;
        wdata_d      = wdata_q;
        dec_d        = dec_q;
        irq_en_d     = irq_en_q;
        done_d       = done_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;

        if (ctrl_wr) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
            irq_en_d  = cfg_wdata[CTRL_IRQ_EN];
            if (!busy) begin
                dec_d = cfg_wdata[CTRL_DEC];
            end
        end

        // Address/count registers are frozen while a transfer owns them.
        if (cfg_we && !busy) begin
            case (cfg_addr)
                REG_SRC_LO: src_d[7:0]        = cfg_wdata;
                REG_SRC_HI: src_d[ADDR_W-1:8] = cfg_wdata[ADDR_W-9:0];
                REG_DST_LO: dst_d[7:0]        = cfg_wdata;
                REG_DST_HI: dst_d[ADDR_W-1:8] = cfg_wdata[ADDR_W-9:0];
                REG_CNT_LO: cnt_d[7:0]        = cfg_wdata;
                REG_CNT_HI: cnt_d[ADDR_W-1:8] = cfg_wdata[ADDR_W-9:0];
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (abort_req) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (dma_ack) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                wdata_d = bus_rdata;
                state_d = ST_WRITE;
                // Abort seen mid-pair is held until the WRITE half has gone out.
                if (abort_req) begin
                    abort_pend_d = 1'b1;
                end
            end
            ST_WRITE: begin
                src_d        = dec_q ? (src_q - ONE) : (src_q + ONE);
                dst_d        = dec_q ? (dst_q - ONE) : (dst_q + ONE);
                cnt_d        = cnt_q - ONE;
                abort_pend_d = 1'b0;
                if (cnt_q == ONE) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (abort_pend_q || abort_req) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (!dma_ack) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= ST_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            cnt_q        <= '0;
            wdata_q      <= '0;
            dec_q        <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            cnt_q        <= cnt_d;
            wdata_q      <= wdata_d;
            dec_q        <= dec_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    always_comb begin
        dma_req   = busy;
        bus_rd    = (state_q == ST_READ);
        bus_wr    = (state_q == ST_WRITE);
        bus_addr  = '0;
        if (state_q == ST_READ) begin
            bus_addr = src_q;
        end else if (state_q == ST_WRITE) begin
            bus_addr = dst_q;
        end
        bus_wdata            = wdata_q;
        status               = '0;
        status[STAT_BUSY]    = busy;
        status[STAT_DONE]    = done_q;
        status[STAT_ABORTED] = aborted_q;
        irq                  = done_q & irq_en_q;
    end

endmodule
